test_bench: RTL and testbench

Registered 1-bit full adder with switching-activity instrumentation. It sits in the arithmetic characterisation path. Gate-level power and timing runs drive all input-pattern transitions through it and read back the sum, the carry, and per-output toggle counts. Inputs are captured, added, and presented on registered outputs with a fixed two-cycle latency.

---
 rtl/test_bench.sv | 84 ++++++++
 tb/tb_test_bench.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/test_bench.sv
// Registered 1-bit full adder with a two-stage pipeline and saturating
// toggle counters on the sum and carry outputs for switching-activity runs.
module test_bench #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CIN,
    input  logic             A,
    input  logic             B,
    output logic             S,
    output logic             COUT,
    output logic             VALID,
    output logic [CNT_W-1:0] S_TGL,
    output logic [CNT_W-1:0] COUT_TGL
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [1:0]       FILL_FULL = 2'd2;

    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             c_q, c_d;
    logic             s_q, s_d;
    logic             cout_q, cout_d;
    logic [1:0]       fill_q, fill_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] s_tgl_q, s_tgl_d;
    logic [CNT_W-1:0] cout_tgl_q, cout_tgl_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        a_d        = A;
        b_d        = B;
        c_d        = CIN;
        s_d        = a_q ^ b_q ^ c_q;
        cout_d     = (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
        fill_d     = (fill_q == FILL_FULL) ? fill_q : fill_q + 2'd1;
        valid_d    = (fill_d == FILL_FULL);
        s_tgl_d    = s_tgl_q;
        cout_tgl_d = cout_tgl_q;

        // The edge that first loads a real result sees valid_q low and is not counted.
        if (valid_q && (s_d != s_q) && (s_tgl_q != CNT_MAX)) begin
            s_tgl_d = s_tgl_q + CNT_ONE;
        end
        if (valid_q && (cout_d != cout_q) && (cout_tgl_q != CNT_MAX)) begin
            cout_tgl_d = cout_tgl_q + CNT_ONE;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            c_q        <= 1'b0;
            s_q        <= 1'b0;
            cout_q     <= 1'b0;
            fill_q     <= 2'd0;
            valid_q    <= 1'b0;
            s_tgl_q    <= '0;
            cout_tgl_q <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            s_q        <= s_d;
            cout_q     <= cout_d;
            fill_q     <= fill_d;
            valid_q    <= valid_d;
            s_tgl_q    <= s_tgl_d;
            cout_tgl_q <= cout_tgl_d;
        end
    end

    assign S        = s_q;
    assign COUT     = cout_q;
    assign VALID    = valid_q;
    assign S_TGL    = s_tgl_q;
    assign COUT_TGL = cout_tgl_q;

endmodule

// File: tb/tb_test_bench.sv
// Self-checking bench for the registered full adder: truth-table vectors,
// pairwise transitions against a scoreboard, reset, first-load and saturation.
module tb_test_bench;

    logic        CLK;
    logic        RST_N;
    logic        CIN, A, B;
    logic        S, COUT, VALID;
    logic [15:0] S_TGL, COUT_TGL;
    logic        s_sat, cout_sat, valid_sat;
    logic [1:0]  s_tgl_sat, cout_tgl_sat;

    test_bench #(.CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .CIN(CIN), .A(A), .B(B),
        .S(S), .COUT(COUT), .VALID(VALID), .S_TGL(S_TGL), .COUT_TGL(COUT_TGL)
    );

    test_bench #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .CIN(CIN), .A(A), .B(B),
        .S(s_sat), .COUT(cout_sat), .VALID(valid_sat),
        .S_TGL(s_tgl_sat), .COUT_TGL(cout_tgl_sat)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [2:0] vec;
        logic [1:0] exp_sum;
    } tt_vec_t;

    tt_vec_t tt[8];

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard state
    logic [2:0] m_stage;
    logic [1:0] m_res;
    int         m_fill;
    bit         m_valid;
    int         m_s_tgl, m_c_tgl, m_s_sat, m_c_sat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_stage = 3'd0;
        m_res   = 2'd0;
        m_fill  = 0;
        m_valid = 1'b0;
        m_s_tgl = 0;
        m_c_tgl = 0;
        m_s_sat = 0;
        m_c_sat = 0;
    endtask

    function automatic logic [1:0] add3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    task automatic check_all();
        check("S", 32'(S), 32'(m_res[0]));
        check("COUT", 32'(COUT), 32'(m_res[1]));
        check("VALID", 32'(VALID), 32'(m_valid));
        check("S_TGL", 32'(S_TGL), m_s_tgl);
        check("COUT_TGL", 32'(COUT_TGL), m_c_tgl);
        check("S_TGL sat", 32'(s_tgl_sat), m_s_sat);
        check("COUT_TGL sat", 32'(cout_tgl_sat), m_c_sat);
    endtask

    // Apply one vector for one clock, advance the scoreboard, compare everything.
    task automatic step(input logic [2:0] v);
        logic [1:0] new_res;
        {B, A, CIN} = v;
        @(posedge CLK);
        #1;
        new_res = add3(m_stage);
        m_stage = v;
        if (m_valid) begin
            if (new_res[0] != m_res[0]) begin
                if (m_s_tgl < 65535) m_s_tgl++;
                if (m_s_sat < 3) m_s_sat++;
            end
            if (new_res[1] != m_res[1]) begin
                if (m_c_tgl < 65535) m_c_tgl++;
                if (m_c_sat < 3) m_c_sat++;
            end
        end
        m_res = new_res;
        if (m_fill < 2) m_fill++;
        m_valid = (m_fill == 2);
        check_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " S"}, 32'(S), 0);
        check({tag, " COUT"}, 32'(COUT), 0);
        check({tag, " VALID"}, 32'(VALID), 0);
        check({tag, " S_TGL"}, 32'(S_TGL), 0);
        check({tag, " COUT_TGL"}, 32'(COUT_TGL), 0);
        check({tag, " S_TGL sat"}, 32'(s_tgl_sat), 0);
        check({tag, " VALID sat"}, 32'(valid_sat), 0);
    endtask

    initial begin
        tt[0] = '{3'd0, 2'b00};
        tt[1] = '{3'd1, 2'b01};
        tt[2] = '{3'd2, 2'b01};
        tt[3] = '{3'd3, 2'b10};
        tt[4] = '{3'd4, 2'b01};
        tt[5] = '{3'd5, 2'b10};
        tt[6] = '{3'd6, 2'b10};
        tt[7] = '{3'd7, 2'b11};

        model_clear();
        RST_N = 1'b0;
        {B, A, CIN} = 3'd0;
        #3;
        check_zero("power-on reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // First-load exclusion with vector 7 held.
        step(3'd7);
        check("first load VALID after 1 edge", 32'(VALID), 0);
        step(3'd7);
        check("first load VALID after 2 edges", 32'(VALID), 1);
        check("first load S", 32'(S), 1);
        check("first load COUT", 32'(COUT), 1);
        check("first load S_TGL", 32'(S_TGL), 0);
        check("first load COUT_TGL", 32'(COUT_TGL), 0);
        step(3'd7);
        step(3'd7);
        check("held 7 S_TGL", 32'(S_TGL), 0);

        // Alternate 0/7: both counters advance once per cycle, narrow ones stop at 3.
        step(3'd0);
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 0) ? 3'd7 : 3'd0);
            check("toggle S_TGL", 32'(S_TGL), i + 1);
            check("toggle COUT_TGL", 32'(COUT_TGL), i + 1);
            check("toggle S_TGL sat", 32'(s_tgl_sat), (i + 1 > 3) ? 3 : i + 1);
            check("toggle COUT_TGL sat", 32'(cout_tgl_sat), (i + 1 > 3) ? 3 : i + 1);
        end

        // Mid-stream reset with S = 1 and nonzero counters, asserted away from an edge.
        check("pre-reset S", 32'(S), 1);
        check("pre-reset S_TGL", 32'(S_TGL), 10);
        #2;
        RST_N = 1'b0;
        #1;
        check_zero("async reset");
        model_clear();
        @(negedge CLK);
        RST_N = 1'b1;
        step(3'd0);
        check("post-reset VALID after 1 edge", 32'(VALID), 0);
        step(3'd0);
        check("post-reset VALID after 2 edges", 32'(VALID), 1);
        check("post-reset S_TGL", 32'(S_TGL), 0);

        // Truth table, one vector per cycle; result appears one step later.
        for (int i = 0; i < 8; i++) begin
            step(tt[i].vec);
            if (i >= 1) check("truth table", 32'({COUT, S}), 32'(tt[i-1].exp_sum));
        end
        step(3'd0);
        check("truth table", 32'({COUT, S}), 32'(tt[7].exp_sum));

        // Pairwise transitions i -> j for every i < j, then 7 -> 0.
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                for (int k = 0; k < 5; k++) step(3'(i));
                for (int k = 0; k < 5; k++) step(3'(j));
            end
        end
        for (int k = 0; k < 5; k++) step(3'd0);
        check("pairwise final sum", 32'({COUT, S}), 0);
        check("S_TGL sat held", 32'(s_tgl_sat), 3);
        check("COUT_TGL sat held", 32'(cout_tgl_sat), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
